// File: rtl/cram_arb_pkg.sv
// Shared types for the cartridge-RAM arbiter: FSM states, grant IDs, latency counter width.
// No logic, so no latency; backpressure is handled by the users of these types.
package cram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CPU  = 2'd1;
  localparam logic [1:0] GNT_SS   = 2'd2;
  localparam logic [1:0] GNT_BK   = 2'd3;

  // Wide enough to count RD_LAT up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/cram_arb_if.sv
// Requester ports, SRAM word bus and status of the cartridge-RAM arbiter in one bundle.
// Wiring only: no latency; requesters hold req until their one-cycle ack.
interface cram_arb_if #(
  parameter int ADDR_W = 17
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              ss_req;
  logic              ss_we;
  logic [ADDR_W-1:0] ss_addr;
  logic [7:0]        ss_wdata;
  logic              ss_ack;
  logic [7:0]        ss_rdata;

  logic              bk_req;
  logic              bk_we;
  logic [ADDR_W-2:0] bk_addr;
  logic [15:0]       bk_wdata;
  logic              bk_ack;
  logic [15:0]       bk_rdata;

  logic              mem_we;
  logic              mem_ub;
  logic              mem_lb;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_d;
  logic [15:0]       mem_q;

  logic              busy;
  logic [1:0]        grant;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ss_req, ss_we, ss_addr, ss_wdata,
    output ss_ack, ss_rdata,
    input  bk_req, bk_we, bk_addr, bk_wdata,
    output bk_ack, bk_rdata,
    output mem_we, mem_ub, mem_lb, mem_addr, mem_d,
    input  mem_q,
    output busy, grant
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ss_req, ss_we, ss_addr, ss_wdata,
    input  ss_ack, ss_rdata,
    output bk_req, bk_we, bk_addr, bk_wdata,
    input  bk_ack, bk_rdata,
    input  mem_we, mem_ub, mem_lb, mem_addr, mem_d,
    output mem_q,
    input  busy, grant
  );
endinterface

// File: rtl/cram_arb_prio.sv
// Combinational requester picker: BK > SS > CPU, except CPU wins right after a non-CPU grant.
// Zero latency; a losing requester simply keeps its request up and is picked later.
module cram_arb_prio
  import cram_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       ss_req,
  input  logic       bk_req,
  input  logic       cpu_first,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (cpu_req && cpu_first) gnt = GNT_CPU;
    else if (bk_req)          gnt = GNT_BK;
    else if (ss_req)          gnt = GNT_SS;
    else if (cpu_req)         gnt = GNT_CPU;
  end

endmodule

// File: rtl/cram_arbiter.sv
// Shares the cartridge-RAM word bus between BK, SS and CPU; write ack at t+2, read ack at t+RD_LAT+1.
// One transaction in flight; other requesters wait with req held until granted.
module cram_arbiter
  import cram_arb_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 17
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  cram_arb_if.master bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_t            state_q, state_d;
  logic [1:0]        grant_q, pick;
  logic              fair_q, we_q, byte_q, ub_q, lb_q, cap;
  logic [ADDR_W-2:0] addr_q;
  logic [15:0]       wdata_q, bk_rdata_q;
  logic [7:0]        cpu_rdata_q, ss_rdata_q, lane_byte;
  logic [CNT_W-1:0]  cnt_q;

  cram_arb_prio u_prio (
    .cpu_req   (bus.cpu_req),
    .ss_req    (bus.ss_req),
    .bk_req    (bus.bk_req),
    .cpu_first (fair_q),
    .gnt       (pick)
  );

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE:  if (pick != GNT_NONE) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else if (RD_LAT == 1) begin
          cap     = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST) begin
          cap     = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobe and lanes are decoded from the state register so reset kills them asynchronously.
  assign bus.mem_we    = (state_q == ST_ISSUE) && we_q;
  assign bus.mem_ub    = bus.mem_we && ub_q;
  assign bus.mem_lb    = bus.mem_we && lb_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_d     = wdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant     = grant_q;
  assign bus.cpu_ack   = (state_q == ST_DONE) && (grant_q == GNT_CPU);
  assign bus.ss_ack    = (state_q == ST_DONE) && (grant_q == GNT_SS);
  assign bus.bk_ack    = (state_q == ST_DONE) && (grant_q == GNT_BK);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ss_rdata  = ss_rdata_q;
  assign bus.bk_rdata  = bk_rdata_q;
  assign lane_byte     = byte_q ? bus.mem_q[15:8] : bus.mem_q[7:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      grant_q     <= GNT_NONE;
      fair_q      <= 1'b0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      ub_q        <= 1'b0;
      lb_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ss_rdata_q  <= '0;
      bk_rdata_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && pick != GNT_NONE) begin
        grant_q <= pick;
        fair_q  <= (pick != GNT_CPU);
        case (pick)
          GNT_CPU: begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr[ADDR_W-1:1];
            wdata_q <= {bus.cpu_wdata, bus.cpu_wdata};
            byte_q  <= bus.cpu_addr[0];
            ub_q    <= bus.cpu_addr[0];
            lb_q    <= ~bus.cpu_addr[0];
          end
          GNT_SS: begin
            we_q    <= bus.ss_we;
            addr_q  <= bus.ss_addr[ADDR_W-1:1];
            wdata_q <= {bus.ss_wdata, bus.ss_wdata};
            byte_q  <= bus.ss_addr[0];
            ub_q    <= bus.ss_addr[0];
            lb_q    <= ~bus.ss_addr[0];
          end
          default: begin
            we_q    <= bus.bk_we;
            addr_q  <= bus.bk_addr;
            wdata_q <= bus.bk_wdata;
            byte_q  <= 1'b0;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
          end
        endcase
      end
      if (state_q == ST_DONE) grant_q <= GNT_NONE;
      if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
      else                    cnt_q <= '0;
      if (cap) begin
        case (grant_q)
          GNT_CPU: cpu_rdata_q <= lane_byte;
          GNT_SS:  ss_rdata_q  <= lane_byte;
          GNT_BK:  bk_rdata_q  <= bus.mem_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed scoreboard bench for cram_arbiter: driver pushes expected bus writes and acks,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cram_arbiter;
  import cram_arb_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  cram_arb_if #(.ADDR_W(17)) bus ();

  cram_arbiter #(.RD_LAT(2), .ADDR_W(17)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] d;
    logic        ub;
    logic        lb;
  } wr_e_t;

  typedef struct {
    int          cyc;
    logic [1:0]  port;
    logic        chk;
    logic [15:0] rdata;
  } ack_e_t;

  wr_e_t  wr_q[$];
  ack_e_t ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_wr(input int c, input logic [15:0] a, input logic [15:0] d,
                        input logic ub, input logic lb);
    wr_e_t w;
    w.cyc = c; w.addr = a; w.d = d; w.ub = ub; w.lb = lb;
    wr_q.push_back(w);
  endtask

  task automatic exp_ack(input int c, input logic [1:0] p, input logic chk, input logic [15:0] rd);
    ack_e_t a;
    a.cyc = c; a.port = p; a.chk = chk; a.rdata = rd;
    ack_q.push_back(a);
  endtask

  // Monitor: every bus write and every ack must match the oldest expectation.
  always @(negedge clk_sys) begin
    wr_e_t       w;
    ack_e_t      a;
    logic [1:0]  p;
    logic [15:0] rd;
    if (!bus.mem_we) begin
      check("lanes_idle", {30'd0, bus.mem_ub, bus.mem_lb}, 32'd0);
    end else if (wr_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", bus.mem_addr, bus.mem_d);
    end else begin
      w = wr_q.pop_front();
      check("wr_cycle", cyc, w.cyc);
      check("wr_addr", {16'd0, bus.mem_addr}, {16'd0, w.addr});
      check("wr_data", {16'd0, bus.mem_d}, {16'd0, w.d});
      check("wr_lanes", {30'd0, bus.mem_ub, bus.mem_lb}, {30'd0, w.ub, w.lb});
    end
    if (bus.cpu_ack || bus.ss_ack || bus.bk_ack) begin
      check("one_ack", $countones({bus.bk_ack, bus.ss_ack, bus.cpu_ack}), 1);
      p  = bus.bk_ack ? GNT_BK : (bus.ss_ack ? GNT_SS : GNT_CPU);
      rd = (p == GNT_BK) ? bus.bk_rdata : (p == GNT_SS) ? {8'd0, bus.ss_rdata} : {8'd0, bus.cpu_rdata};
      if (ack_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack: port %0d with none expected", p);
      end else begin
        a = ack_q.pop_front();
        check("ack_port", {30'd0, p}, {30'd0, a.port});
        check("ack_cycle", cyc, a.cyc);
        if (a.chk) check("rdata", {16'd0, rd}, {16'd0, a.rdata});
      end
    end
  end

  task automatic idle_all();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ss_req  = 0; bus.ss_we  = 0; bus.ss_addr  = '0; bus.ss_wdata  = '0;
    bus.bk_req  = 0; bus.bk_we  = 0; bus.bk_addr  = '0; bus.bk_wdata  = '0;
  endtask

  // Wait for n acks (bounded), drop all requests on the last one, then step into IDLE.
  task automatic wait_acks(input int n, input string name);
    int seen   = 0;
    int budget = 0;
    while (seen < n && budget < 40) begin
      @(negedge clk_sys);
      budget++;
      if (bus.cpu_ack || bus.ss_ack || bus.bk_ack) seen++;
    end
    checks++;
    if (seen < n) begin
      failures++;
      $display("FAIL %s_timeout: saw %0d acks expected %0d", name, seen, n);
    end
    idle_all();
    @(negedge clk_sys);
  endtask

  int t, r;

  initial begin
    reset_n = 1'b0;
    idle_all();
    bus.mem_q = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_acks", {bus.cpu_ack, bus.ss_ack, bus.bk_ack}, 0);
    check("rst_rdata", {bus.cpu_rdata, bus.ss_rdata, bus.bk_rdata}, 0);
    check("rst_bus", {bus.mem_addr, bus.mem_d}, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // CPU byte write, odd address -> upper lane
    t = cyc;
    check("idle_cpu_wr", bus.busy, 0);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 17'h00005; bus.cpu_wdata = 8'hA5;
    exp_wr(t + 1, 16'h0002, 16'hA5A5, 1'b1, 1'b0);
    exp_ack(t + 2, GNT_CPU, 1'b0, 16'h0);
    wait_acks(1, "cpu_wr");

    // BK and CPU held together: BK, CPU, BK, CPU
    t = cyc;
    check("idle_contend", bus.busy, 0);
    bus.bk_req  = 1; bus.bk_we  = 1; bus.bk_addr  = 16'h0100;  bus.bk_wdata  = 16'hC0DE;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 17'h00021; bus.cpu_wdata = 8'h99;
    exp_wr(t + 1,  16'h0100, 16'hC0DE, 1'b1, 1'b1); exp_ack(t + 2,  GNT_BK,  1'b0, 16'h0);
    exp_wr(t + 4,  16'h0010, 16'h9999, 1'b1, 1'b0); exp_ack(t + 5,  GNT_CPU, 1'b0, 16'h0);
    exp_wr(t + 7,  16'h0100, 16'hC0DE, 1'b1, 1'b1); exp_ack(t + 8,  GNT_BK,  1'b0, 16'h0);
    exp_wr(t + 10, 16'h0010, 16'h9999, 1'b1, 1'b0); exp_ack(t + 11, GNT_CPU, 1'b0, 16'h0);
    wait_acks(4, "contend");

    // SS byte reads, low then high lane
    t = cyc;
    bus.mem_q = 16'h3C7E;
    bus.ss_req = 1; bus.ss_we = 0; bus.ss_addr = 17'h00004;
    exp_ack(t + 3, GNT_SS, 1'b1, 16'h007E);
    wait_acks(1, "ss_rd_lo");
    t = cyc;
    bus.ss_req = 1; bus.ss_we = 0; bus.ss_addr = 17'h00005;
    exp_ack(t + 3, GNT_SS, 1'b1, 16'h003C);
    wait_acks(1, "ss_rd_hi");

    // BK word write and word read
    t = cyc;
    bus.bk_req = 1; bus.bk_we = 1; bus.bk_addr = 16'h1234; bus.bk_wdata = 16'hBEEF;
    exp_wr(t + 1, 16'h1234, 16'hBEEF, 1'b1, 1'b1);
    exp_ack(t + 2, GNT_BK, 1'b0, 16'h0);
    wait_acks(1, "bk_wr");
    t = cyc;
    bus.mem_q = 16'h1357;
    bus.bk_req = 1; bus.bk_we = 0; bus.bk_addr = 16'h0ABC;
    exp_ack(t + 3, GNT_BK, 1'b1, 16'h1357);
    wait_acks(1, "bk_rd");

    // CPU read abandoned at t+1; SS write waiting behind it is evaluated at t+4
    t = cyc;
    bus.mem_q = 16'h55AA;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 17'h00010;
    exp_ack(t + 3, GNT_CPU, 1'b1, 16'h00AA);
    @(negedge clk_sys);
    bus.cpu_req = 0;
    bus.ss_req = 1; bus.ss_we = 1; bus.ss_addr = 17'h00007; bus.ss_wdata = 8'h5A;
    exp_wr(t + 5, 16'h0003, 16'h5A5A, 1'b1, 1'b0);
    exp_ack(t + 6, GNT_SS, 1'b0, 16'h0);
    wait_acks(2, "abandon");

    // Reset during WAIT of an SS read
    bus.mem_q = 16'h3C7E;
    bus.ss_req = 1; bus.ss_we = 0; bus.ss_addr = 17'h00004;
    repeat (2) @(negedge clk_sys);
    check("wait_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem_we", bus.mem_we, 0);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_acks", {bus.cpu_ack, bus.ss_ack, bus.bk_ack}, 0);
    check("mid_rst_rdata", {bus.cpu_rdata, bus.ss_rdata}, 0);
    bus.ss_we = 1; bus.ss_addr = 17'h00009; bus.ss_wdata = 8'h77;
    @(negedge clk_sys);
    reset_n = 1'b1;
    r = cyc;
    exp_wr(r + 1, 16'h0004, 16'h7777, 1'b1, 1'b0);
    exp_ack(r + 2, GNT_SS, 1'b0, 16'h0);
    @(negedge clk_sys);
    check("post_rst_grant", bus.grant, GNT_SS);
    wait_acks(1, "post_rst");

    check("wr_q_drained", wr_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
